uart_word_ctrl: RTL and testbench
=================================

UART_WORD_CTRL -- requirements
Module: uart_word_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the TX and RX word buses.
REQ-002 SHALL have parameter BYTES_PER_WORD, default 4: bytes per word, legal range 1 to DATA_WIDTH/8.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 10: clk cycles per serial bit, minimum 4.
REQ-004 SHALL have parameter TX_DEPTH, default 4: TX word FIFO entries, power of 2, minimum 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port SerialDataIn, input, 1 bit: RX serial line, asynchronous to clk.
REQ-008 SHALL have port SerialDataOut, output, 1 bit: TX serial line, idles high.
REQ-009 SHALL have port uart_tx, input, DATA_WIDTH bits: word to transmit.
REQ-010 SHALL have port Start_Tx, input, 1 bit: one-cycle push strobe for uart_tx.
REQ-011 SHALL have port tx_full, output, 1 bit: TX FIFO full.
REQ-012 SHALL have port tx_busy, output, 1 bit: FIFO non-empty or a frame in progress.
REQ-013 SHALL have port clr_rx_flag, input, 1 bit: active-high pulse; clears the RX status.
REQ-014 SHALL have port UART_data, output, DATA_WIDTH bits: last assembled RX word, zero-extended.
REQ-015 SHALL have port Rx_flag_out, output, DATA_WIDTH bits: bit0 = word received; upper bits always 0.
REQ-016 SHALL have port rx_overrun, output, 1 bit: sticky; a word completed while Rx_flag was set.
REQ-017 SHALL have port rx_frame_err, output, 1 bit: sticky; a stop bit was sampled low.

Function
REQ-018 SHALL push uart_tx on Start_Tx when not full; a push while full is dropped and the FIFO is unchanged.
REQ-019 SHALL run the TX FSM IDLE->LOAD->START->DATA->STOP, with STOP going to START for the next byte, LOAD for the next word, or IDLE when the FIFO is empty.
REQ-020 SHALL frame TX as 8N1, CLKS_PER_BIT cycles per bit, LSB bit first and lowest byte first, sending BYTES_PER_WORD bytes per word.
REQ-021 SHALL drive the start bit low 2 cycles after Start_Tx when the FIFO is empty and TX is IDLE; a word popped after STOP sends its start bit 1 cycle after LOAD.
REQ-022 SHALL synchronise SerialDataIn with 2 flops and detect a start on a high-to-low transition while RX is IDLE.
REQ-023 SHALL resample at CLKS_PER_BIT/2 and abort to IDLE with no side effects if the line is high again.
REQ-024 SHALL sample 8 data bits and the stop bit at mid-bit, using RX states IDLE, START, DATA, STOP.
REQ-025 SHALL discard a byte with a low stop bit, set rx_frame_err, and reset byte assembly to byte 0.
REQ-026 SHALL place each good byte into the assembly register at byte index 0..BYTES_PER_WORD-1.
REQ-027 SHALL, after the last byte with Rx_flag clear, load UART_data and set Rx_flag_out[0] in the next cycle.
REQ-028 SHALL, after the last byte with Rx_flag set, keep UART_data unchanged, set rx_overrun, and discard the word.
REQ-029 SHALL make clr_rx_flag clear Rx_flag, rx_overrun and rx_frame_err; if it coincides with word completion, the completion wins: new data is loaded and the flag stays 1.
REQ-030 SHALL run TX and RX fully independently and concurrently.

Reset
REQ-031 SHALL, while reset is high, force SerialDataOut=1, tx_full=0, tx_busy=0, UART_data=0, Rx_flag_out=0, rx_overrun=0, rx_frame_err=0, FIFO empty, and both FSMs to IDLE.
REQ-032 SHALL abort any frame in progress on reset, including mid-frame; partial TX or RX words are lost and nothing resumes after release.

Configuration
REQ-033 SHALL, when UART_CTRL_ASCII_EN is defined, map RX bytes 0x30-0x39 to 0x00-0x09 before assembly and TX bytes 0x00-0x09 to 0x30-0x39 before serialising; other byte values pass unchanged.
REQ-034 SHALL, when UART_CTRL_ASCII_EN is undefined, pass all bytes raw and instantiate no translation logic.

Verification (CLKS_PER_BIT=10, BYTES_PER_WORD=4, TX_DEPTH=4, macro off unless stated)
REQ-035 SHALL check: push 0x12345678 -> frames 0x78, 0x56, 0x34, 0x12 of 100 clk each, and tx_busy falls 400 clk after the first start bit.
REQ-036 SHALL check: 6 back-to-back pushes -> tx_full=1 after push 5, push 6 dropped, and exactly 5 words on the line.
REQ-037 SHALL check: RX bytes 0x01, 0x02, 0x03, 0x04 -> UART_data=0x04030201 and Rx_flag_out=0x00000001; then clr_rx_flag -> Rx_flag_out=0.
REQ-038 SHALL check: a second RX word with no clear -> UART_data stays 0x04030201 and rx_overrun=1; a clear in the completion cycle -> Rx_flag stays 1.
REQ-039 SHALL check: a 3-clk low glitch gives no byte; a frame with stop bit 0 sets rx_frame_err=1; reset mid-TX-frame drives SerialDataOut=1 immediately.
REQ-040 SHALL check, with UART_CTRL_ASCII_EN defined: RX 0x35, 0x41, 0x30, 0x39 -> UART_data=0x09004105; TX word 0x00000007 -> first byte sent 0x37.

Source files
------------

// File: rtl/uart_word_ctrl.sv
// Word-oriented 8N1 UART: TX word FIFO with byte serialiser, RX byte sampler with word assembly.
// Define UART_CTRL_ASCII_EN to translate ASCII digits on both directions.
`timescale 1ns/1ps
module uart_word_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned CLKS_PER_BIT   = 10,
    parameter int unsigned TX_DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SerialDataIn,
    output logic                  SerialDataOut,
    input  logic [DATA_WIDTH-1:0] uart_tx,
    input  logic                  Start_Tx,
    output logic                  tx_full,
    output logic                  tx_busy,
    input  logic                  clr_rx_flag,
    output logic [DATA_WIDTH-1:0] UART_data,
    output logic [DATA_WIDTH-1:0] Rx_flag_out,
    output logic                  rx_overrun,
    output logic                  rx_frame_err
);
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W  = $clog2(TX_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned ASM_W  = 8 * BYTES_PER_WORD;
    localparam logic [CNT_W-1:0]  BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

`ifdef UART_CTRL_ASCII_EN
    function automatic logic [7:0] rx_xlate(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ? (b - 8'h30) : b;
    endfunction
    function automatic logic [7:0] tx_xlate(input logic [7:0] b);
        return (b <= 8'h09) ? (b + 8'h30) : b;
    endfunction
`else
    function automatic logic [7:0] rx_xlate(input logic [7:0] b);
        return b;
    endfunction
    function automatic logic [7:0] tx_xlate(input logic [7:0] b);
        return b;
    endfunction
`endif

    typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // TX FIFO
    logic [DATA_WIDTH-1:0] fifo_mem_q [TX_DEPTH];
    logic [FILL_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_d;
    logic                  tx_full_q, tx_full_d, tx_busy_q, tx_busy_d;
    logic                  push_c, pop_c, fifo_empty_c;
    logic [DATA_WIDTH-1:0] fifo_head_c;

    tx_state_e             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [2:0]            tx_bit_q, tx_bit_d;
    logic [BIDX_W-1:0]     tx_byte_q, tx_byte_d;
    logic [DATA_WIDTH-1:0] tx_word_q, tx_word_d;
    logic [7:0]            tx_shift_q, tx_shift_d;
    logic                  tx_out_q, tx_out_d;

    assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
    assign push_c       = Start_Tx && !tx_full_q;
    assign fifo_head_c  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= uart_tx;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + FILL_W'(push_c);
        rd_ptr_d  = rd_ptr_q + FILL_W'(pop_c);
        fill_d    = wr_ptr_d - rd_ptr_d;
        tx_full_d = (fill_d == FILL_W'(TX_DEPTH));
        tx_busy_d = (tx_state_d != TX_IDLE) || (fill_d != '0);
    end

    // TX frame sequencer; a word is popped on every entry to LOAD
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_word_d  = tx_word_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        pop_c      = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_out_d = 1'b1;
                if (!fifo_empty_c) begin
                    tx_state_d = TX_LOAD;
                    tx_word_d  = fifo_head_c;
                    pop_c      = 1'b1;
                end
            end
            TX_LOAD: begin
                tx_state_d = TX_START;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_byte_d  = '0;
                tx_shift_d = tx_xlate(tx_word_q[7:0]);
                tx_word_d  = tx_word_q >> 8;
                tx_out_d   = 1'b0;
            end
            TX_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_out_d   = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_out_d   = tx_shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    tx_bit_d = '0;
                    if (tx_byte_q != LAST_BYTE) begin
                        tx_state_d = TX_START;
                        tx_byte_d  = tx_byte_q + BIDX_W'(1);
                        tx_shift_d = tx_xlate(tx_word_q[7:0]);
                        tx_word_d  = tx_word_q >> 8;
                        tx_out_d   = 1'b0;
                    end else if (!fifo_empty_c) begin
                        tx_state_d = TX_LOAD;
                        tx_word_d  = fifo_head_c;
                        pop_c      = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_word_q  <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_full_q  <= tx_full_d;
            tx_busy_q  <= tx_busy_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_word_q  <= tx_word_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
        end
    end

    // RX path
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [BIDX_W-1:0] rx_idx_q, rx_idx_d;
    logic [ASM_W-1:0]  rx_asm_q, rx_asm_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_ferr_c;
    logic [7:0]        rx_byte_c;

    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_flag_q, rx_flag_d;
    logic                  rx_ovr_q, rx_ovr_d;
    logic                  rx_ferr_q, rx_ferr_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_idx_d   = rx_idx_q;
        rx_asm_d   = rx_asm_q;
        rx_done_d  = 1'b0;
        rx_ferr_c  = 1'b0;
        rx_byte_c  = rx_xlate(rx_shift_q);
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // line back high at mid start bit: treat as a glitch
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s2_q) begin
                        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                            if (rx_idx_q == BIDX_W'(i)) rx_asm_d[8*i +: 8] = rx_byte_c;
                        end
                        if (rx_idx_q == LAST_BYTE) begin
                            rx_idx_d  = '0;
                            rx_done_d = 1'b1;
                        end else begin
                            rx_idx_d = rx_idx_q + BIDX_W'(1);
                        end
                    end else begin
                        rx_ferr_c = 1'b1;
                        rx_idx_d  = '0;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // status: a word completing in the same cycle as a clear still lands
    always_comb begin
        rx_data_d = rx_data_q;
        rx_flag_d = rx_flag_q;
        rx_ovr_d  = rx_ovr_q;
        rx_ferr_d = rx_ferr_q;
        if (clr_rx_flag) begin
            rx_flag_d = 1'b0;
            rx_ovr_d  = 1'b0;
            rx_ferr_d = 1'b0;
        end
        if (rx_ferr_c) rx_ferr_d = 1'b1;
        if (rx_done_q) begin
            if (!rx_flag_q || clr_rx_flag) begin
                rx_data_d = DATA_WIDTH'(rx_asm_q);
                rx_flag_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_idx_q   <= '0;
            rx_asm_q   <= '0;
            rx_done_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_flag_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_s1_q    <= SerialDataIn;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_idx_q   <= rx_idx_d;
            rx_asm_q   <= rx_asm_d;
            rx_done_q  <= rx_done_d;
            rx_data_q  <= rx_data_d;
            rx_flag_q  <= rx_flag_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign SerialDataOut = tx_out_q;
    assign tx_full       = tx_full_q;
    assign tx_busy       = tx_busy_q;
    assign UART_data     = rx_data_q;
    assign Rx_flag_out   = DATA_WIDTH'(rx_flag_q);
    assign rx_overrun    = rx_ovr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_word_ctrl.sv
// Scoreboard bench for uart_word_ctrl: TX bytes decoded off the line, RX words driven serially.
`timescale 1ns/1ps
module tb_uart_word_ctrl;
    localparam int unsigned DW  = 32;
    localparam int unsigned BPW = 4;
    localparam int unsigned CPB = 10;
    localparam int unsigned DEP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          SerialDataIn;
    logic          SerialDataOut;
    logic [DW-1:0] uart_tx;
    logic          Start_Tx;
    logic          tx_full;
    logic          tx_busy;
    logic          clr_rx_flag;
    logic [DW-1:0] UART_data;
    logic [DW-1:0] Rx_flag_out;
    logic          rx_overrun;
    logic          rx_frame_err;

    uart_word_ctrl #(
        .DATA_WIDTH(DW), .BYTES_PER_WORD(BPW), .CLKS_PER_BIT(CPB), .TX_DEPTH(DEP)
    ) dut (
        .clk(clk), .reset(reset), .SerialDataIn(SerialDataIn), .SerialDataOut(SerialDataOut),
        .uart_tx(uart_tx), .Start_Tx(Start_Tx), .tx_full(tx_full), .tx_busy(tx_busy),
        .clr_rx_flag(clr_rx_flag), .UART_data(UART_data), .Rx_flag_out(Rx_flag_out),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          tx_frames = 0;
    bit          mon_en = 1'b1;
    logic [7:0]  tx_q [$];
    logic [DW-1:0] rx_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_tx(input logic [7:0] b);
`ifdef UART_CTRL_ASCII_EN
        if (b <= 8'h09) return b + 8'h30;
`endif
        return b;
    endfunction

    function automatic logic [7:0] m_rx(input logic [7:0] b);
`ifdef UART_CTRL_ASCII_EN
        if (b >= 8'h30 && b <= 8'h39) return b - 8'h30;
`endif
        return b;
    endfunction

    function automatic logic [DW-1:0] m_rx_word(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = '0;
        for (int b = 0; b < BPW; b++) r[8*b +: 8] = m_rx(w[8*b +: 8]);
        return r;
    endfunction

    task automatic exp_tx_word(input logic [DW-1:0] w);
        for (int b = 0; b < BPW; b++) tx_q.push_back(m_tx(w[8*b +: 8]));
    endtask

    // decode frames off SerialDataOut, sampling mid-bit on the falling clock edge
    initial begin : tx_mon
        logic       prev;
        logic       start_b;
        logic       stop_b;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !SerialDataOut && !reset) begin
                repeat (CPB/2 - 1) @(negedge clk);
                start_b = SerialDataOut;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = SerialDataOut;
                end
                repeat (CPB) @(negedge clk);
                stop_b = SerialDataOut;
                if (mon_en) begin
                    tx_frames++;
                    chk("tx_start_bit", 64'(start_b), 64'(1'b0));
                    chk("tx_stop_bit", 64'(stop_b), 64'(1'b1));
                    if (tx_q.size() == 0) chk("tx_q_nonempty", 64'(tx_q.size()), 64'd1);
                    else chk("tx_byte", 64'(b), 64'(tx_q.pop_front()));
                end
                prev = stop_b;
            end else begin
                prev = SerialDataOut;
            end
        end
    end

    task automatic wait_tx_idle(input int limit, output int waited);
        waited = 0;
        while (tx_busy && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic wait_rx_flag(input int limit, output int waited);
        waited = 0;
        while (!Rx_flag_out[0] && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        SerialDataIn = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            SerialDataIn = b[i];
            repeat (CPB) @(negedge clk);
        end
        SerialDataIn = stop;
        repeat (CPB) @(negedge clk);
        SerialDataIn = 1'b1;
    endtask

    task automatic rx_word(input logic [DW-1:0] w);
        for (int b = 0; b < BPW; b++) rx_byte(w[8*b +: 8], 1'b1);
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_rx_flag = 1'b1;
        @(negedge clk);
        clr_rx_flag = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int            waited;
        int            frames0;
        int            bad;
        logic [DW-1:0] w;
        logic [DW-1:0] last_data;

        reset        = 1'b1;
        SerialDataIn = 1'b1;
        Start_Tx     = 1'b0;
        uart_tx      = '0;
        clr_rx_flag  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sout", 64'(SerialDataOut), 64'd1);
        chk("rst_full", 64'(tx_full), 64'd0);
        chk("rst_busy", 64'(tx_busy), 64'd0);
        chk("rst_data", 64'(UART_data), 64'd0);
        chk("rst_flag", 64'(Rx_flag_out), 64'd0);
        chk("rst_ovr", 64'(rx_overrun), 64'd0);
        chk("rst_ferr", 64'(rx_frame_err), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single word: latency, byte order, busy duration
        exp_tx_word(32'h12345678);
        uart_tx  = 32'h12345678;
        Start_Tx = 1'b1;
        @(negedge clk);
        Start_Tx = 1'b0;
        @(negedge clk);
        chk("tx_lat_1", 64'(SerialDataOut), 64'd1);
        @(negedge clk);
        chk("tx_lat_2", 64'(SerialDataOut), 64'd0);
        wait_tx_idle(2000, waited);
        chk("tx_busy_fall", 64'(waited), 64'd400);
        chk("tx_frames_1", 64'(tx_frames), 64'd4);
        chk("tx_q_drained_1", 64'(tx_q.size()), 64'd0);

        // back-to-back pushes past FIFO capacity
        repeat (5) @(negedge clk);
        frames0 = tx_frames;
        for (int i = 0; i < 6; i++) begin
            w = {8'(8'hC0 + i), 8'(8'h90 + i), 8'(8'h50 + i), 8'(i)};
            uart_tx  = w;
            Start_Tx = 1'b1;
            if (i < 5) exp_tx_word(w);
            @(negedge clk);
            if (i == 3) chk("tx_full_push4", 64'(tx_full), 64'd0);
            if (i == 4) chk("tx_full_push5", 64'(tx_full), 64'd1);
        end
        Start_Tx = 1'b0;
        chk("tx_full_push6", 64'(tx_full), 64'd1);
        wait_tx_idle(3000, waited);
        chk("tx_burst_idle", 64'(tx_busy), 64'd0);
        chk("tx_burst_frames", 64'(tx_frames - frames0), 64'(5 * BPW));
        chk("tx_q_drained_2", 64'(tx_q.size()), 64'd0);
        chk("tx_full_after", 64'(tx_full), 64'd0);

        // RX word, then clear
        rx_q.push_back(m_rx_word(32'h04030201));
        rx_word(32'h04030201);
        wait_rx_flag(50, waited);
        chk("rx_flag_a", 64'(Rx_flag_out), 64'd1);
        last_data = rx_q.pop_front();
        chk("rx_data_a", 64'(UART_data), 64'(last_data));

        // overrun: second word with flag still set is dropped
        rx_word(32'hDDCCBBAA);
        chk("rx_ovr_data", 64'(UART_data), 64'(last_data));
        chk("rx_ovr_set", 64'(rx_overrun), 64'd1);
        chk("rx_ovr_flag", 64'(Rx_flag_out), 64'd1);
        pulse_clr();
        chk("rx_clr_flag", 64'(Rx_flag_out), 64'd0);
        chk("rx_clr_ovr", 64'(rx_overrun), 64'd0);

        // clear held through the completion cycle: completion wins
        w = 32'h0D0C0B0A;
        rx_q.push_back(m_rx_word(w));
        for (int b = 0; b < BPW - 1; b++) rx_byte(w[8*b +: 8], 1'b1);
        fork
            rx_byte(w[8*(BPW-1) +: 8], 1'b1);
            begin
                int k;
                k = 0;
                repeat (60) @(negedge clk);
                clr_rx_flag = 1'b1;
                while (!Rx_flag_out[0] && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                clr_rx_flag = 1'b0;
            end
        join
        @(negedge clk);
        chk("rx_coinc_flag", 64'(Rx_flag_out), 64'd1);
        last_data = rx_q.pop_front();
        chk("rx_coinc_data", 64'(UART_data), 64'(last_data));
        pulse_clr();

        // bad stop bit mid-word restarts assembly at byte 0
        rx_byte(8'h11, 1'b1);
        rx_byte(8'h22, 1'b1);
        rx_byte(8'h33, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("rx_ferr_set", 64'(rx_frame_err), 64'd1);
        chk("rx_ferr_noflag", 64'(Rx_flag_out), 64'd0);
        pulse_clr();
        chk("rx_ferr_clr", 64'(rx_frame_err), 64'd0);
        rx_q.push_back(m_rx_word(32'h8877665A));
        rx_word(32'h8877665A);
        wait_rx_flag(50, waited);
        chk("rx_realign_flag", 64'(Rx_flag_out), 64'd1);
        last_data = rx_q.pop_front();
        chk("rx_realign_data", 64'(UART_data), 64'(last_data));
        pulse_clr();

        // short low glitch produces no byte
        SerialDataIn = 1'b0;
        repeat (3) @(negedge clk);
        SerialDataIn = 1'b1;
        repeat (200) @(negedge clk);
        chk("rx_glitch_flag", 64'(Rx_flag_out), 64'd0);
        chk("rx_glitch_ferr", 64'(rx_frame_err), 64'd0);
        rx_q.push_back(m_rx_word(32'h4D3C2B1A));
        rx_word(32'h4D3C2B1A);
        wait_rx_flag(50, waited);
        last_data = rx_q.pop_front();
        chk("rx_glitch_data", 64'(UART_data), 64'(last_data));

        // reset in the middle of a TX frame
        mon_en   = 1'b0;
        uart_tx  = 32'h55AA55AA;
        Start_Tx = 1'b1;
        @(negedge clk);
        Start_Tx = 1'b0;
        repeat (120) @(negedge clk);
        waited = 0;
        while (SerialDataOut && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk("tx_low_pre_rst", 64'(SerialDataOut), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_sout", 64'(SerialDataOut), 64'd1);
        chk("rst_mid_busy", 64'(tx_busy), 64'd0);
        chk("rst_mid_data", 64'(UART_data), 64'd0);
        chk("rst_mid_flag", 64'(Rx_flag_out), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!SerialDataOut || tx_busy) bad++;
        end
        chk("rst_no_resume", 64'(bad), 64'd0);
        mon_en = 1'b1;

`ifdef UART_CTRL_ASCII_EN
        // ASCII digit translation in both directions
        rx_q.push_back(32'h09004105);
        rx_word(32'h39304135);
        wait_rx_flag(50, waited);
        chk("asc_rx_data", 64'(UART_data), 64'(rx_q.pop_front()));
        frames0 = tx_frames;
        tx_q.push_back(8'h37);
        tx_q.push_back(8'h30);
        tx_q.push_back(8'h30);
        tx_q.push_back(8'h30);
        uart_tx  = 32'h00000007;
        Start_Tx = 1'b1;
        @(negedge clk);
        Start_Tx = 1'b0;
        wait_tx_idle(1000, waited);
        chk("asc_tx_frames", 64'(tx_frames - frames0), 64'(BPW));
        chk("asc_tx_drained", 64'(tx_q.size()), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
